// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths, slot record and arbiter state type for the register-file write arbiter.
// The statistics counters are built only when RWA_STATS_EN is defined.
package reg_write_arbiter_pkg;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 16;
  localparam int DROP_W  = 8;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  // Which requester won the most recent grant; the other one wins the next tie.
  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_grant_e;

  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cnt,
                                                     input logic [1:0] inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, inc};
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction
endpackage

// File: rtl/reg_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant over the request vector,
// with the last-winner register exposed as last_grant for observation.
module rr_arb2
  import reg_write_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output last_grant_e        last_grant
);
  last_grant_e last_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LAST_REQ1;
    end else begin
      last_grant <= last_next;
    end
  end

  // The winner is remembered only on cycles that actually grant.
  always_comb begin
    last_next = last_grant;
    if (grant[0]) begin
      last_next = LAST_REQ0;
    end else if (grant[1]) begin
      last_next = LAST_REQ1;
    end
  end

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == LAST_REQ1) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Two requesters, one holding slot each, arbitrated round-robin onto one register-file write port.
// Define RWA_STATS_EN to build the Write_Count / Drop_Count statistics counters.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0_Valid,
  input  logic [ADDR_W-1:0] Req0_Addr,
  input  logic [DATA_W-1:0] Req0_Data,
  output logic              Req0_Ready,
  input  logic              Req1_Valid,
  input  logic [ADDR_W-1:0] Req1_Addr,
  input  logic [DATA_W-1:0] Req1_Data,
  output logic              Req1_Ready,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              Grant_Id,
  output logic [CNT_W-1:0]  Write_Count,
  output logic [DROP_W-1:0] Drop_Count
);
  // Handshake: a request transfers on a rising edge where Valid && Ready.
  // Ready is high when the slot is empty or is being drained this cycle,
  // and is forced low while Reset is asserted.
  logic [NUM_REQ-1:0] req_valid;
  logic [ADDR_W-1:0]  req_addr [NUM_REQ];
  logic [DATA_W-1:0]  req_data [NUM_REQ];
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] load;
  logic [NUM_REQ-1:0] drop;
  logic [NUM_REQ-1:0] hold_valid;
  logic [NUM_REQ-1:0] grant;
  slot_t              slot_q [NUM_REQ];
  last_grant_e        arb_state;

  assign req_valid   = {Req1_Valid, Req0_Valid};
  assign req_addr[0] = Req0_Addr;
  assign req_addr[1] = Req1_Addr;
  assign req_data[0] = Req0_Data;
  assign req_data[1] = Req1_Data;
  assign Req0_Ready  = ready[0];
  assign Req1_Ready  = ready[1];

  always_comb begin
    hold_valid = '0;
    ready      = '0;
    load       = '0;
    drop       = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      hold_valid[n] = slot_q[n].valid;
      ready[n]      = !Reset && (!slot_q[n].valid || grant[n]);
      load[n]       = req_valid[n] && ready[n] && (req_addr[n] != '0);
      drop[n]       = req_valid[n] && ready[n] && (req_addr[n] == '0);
    end
  end

  // Masking the requests during Reset keeps stale slots from producing a write.
  rr_arb2 u_arb (
    .clk        (Clk),
    .reset      (Reset),
    .req        (hold_valid & {NUM_REQ{~Reset}}),
    .grant      (grant),
    .last_grant (arb_state)
  );

  // A refill on the draining edge wins over the clear.
  always_ff @(posedge Clk) begin
    for (int n = 0; n < NUM_REQ; n++) begin
      if (Reset) begin
        slot_q[n] <= '0;
      end else if (load[n]) begin
        slot_q[n] <= '{valid: 1'b1, addr: req_addr[n], data: req_data[n]};
      end else if (grant[n]) begin
        slot_q[n].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    Write_Reg = |grant;
    W_Addr    = '0;
    W_Data    = '0;
    Grant_Id  = 1'b0;
    if (grant[1]) begin
      W_Addr   = slot_q[1].addr;
      W_Data   = slot_q[1].data;
      Grant_Id = 1'b1;
    end else if (grant[0]) begin
      W_Addr = slot_q[0].addr;
      W_Data = slot_q[0].data;
    end
  end

`ifdef RWA_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Write_Count <= '0;
      Drop_Count  <= '0;
    end else begin
      if (Write_Reg) begin
        Write_Count <= Write_Count + 16'd1;
      end
      Drop_Count <= sat_add_drop(Drop_Count, {1'b0, drop[0]} + {1'b0, drop[1]});
    end
  end
`else
  assign Write_Count = '0;
  assign Drop_Count  = '0;
`endif
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: Clk samples all state on its rising edge, and Reset clears state only at a rising Clk edge.
REQ-002 Port list, as name / direction / width / meaning:
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- Req0_Valid  in  1  requester 0 write request
- Req0_Addr  in  5  requester 0 destination register
- Req0_Data  in  32  requester 0 write data
- Req0_Ready  out  1  requester 0 request accepted this cycle
- Req1_Valid  in  1  requester 1 write request
- Req1_Addr  in  5  requester 1 destination register
- Req1_Data  in  32  requester 1 write data
- Req1_Ready  out  1  requester 1 request accepted this cycle
- W_Addr  out  5  register-file write address
- W_Data  out  32  register-file write data
- Write_Reg  out  1  register-file write enable
- Grant_Id  out  1  requester owning the current write
- Write_Count  out  16  statistics: writes issued
- Drop_Count  out  8  statistics: address-0 requests dropped

Function
REQ-003 Each requester SHALL own one holding slot: Hold_Valid, Hold_Addr, Hold_Data.
REQ-004 A transfer SHALL occur on an edge where ReqN_Valid && ReqN_Ready; when ReqN_Addr != 0, it loads slot N.
REQ-005 ReqN_Ready SHALL equal !Hold_Valid[N] || Grant[N], so a slot can be refilled in the same cycle it drains.
REQ-006 A transfer with ReqN_Addr == 0 SHALL be accepted and discarded: the slot is not loaded and no write cycle is used.
REQ-007 Arbitration SHALL be combinational over the slots. With one valid slot, that slot is granted. With both valid, the requester not granted last is granted.
REQ-008 Last_Grant SHALL update only on edges where a grant occurs.
REQ-009 When a grant occurs, Write_Reg SHALL be 1 and W_Addr, W_Data and Grant_Id SHALL come from the granted slot. That slot clears at the next edge unless it is refilled on that same edge.
REQ-010 Latency SHALL be as follows: a request accepted at edge N drives Write_Reg during cycle N+1 when uncontended, and no later than cycle N+2 when contended.
REQ-011 Throughput SHALL be one write per cycle in aggregate, and one write per cycle for a single active requester.
REQ-012 When no slot is valid, Write_Reg, W_Addr, W_Data and Grant_Id SHALL all be 0.
REQ-013 Ordering between requesters targeting the same address SHALL follow grant order only. No merging is performed.
REQ-014 Write_Reg SHALL never be asserted with W_Addr == 0.

Reset
REQ-015 Reset SHALL clear Hold_Valid to 0 and both slot data fields to 0, and set Last_Grant=1 so that requester 0 wins first contention.
REQ-016 Reset SHALL clear Write_Count and Drop_Count to 0.
REQ-017 While Reset is asserted, ReqN_Ready, Write_Reg, W_Addr, W_Data and Grant_Id SHALL all be 0.
REQ-018 Requests held or offered during Reset SHALL be lost.

Configuration
REQ-019 Macro RWA_STATS_EN, when defined, SHALL implement both counters:
- Write_Count increments on each Write_Reg cycle and wraps at 16 bits.
- Drop_Count increments on each address-0 transfer and saturates at 255.
- When both requesters drop in the same cycle, Drop_Count increments by 2, saturating.
REQ-020 Without RWA_STATS_EN, no counter logic SHALL exist and Write_Count and Drop_Count SHALL be tied to 0.

Structure
REQ-021 A shared definitions package SHALL hold ADDR_W=5, DATA_W=32, NUM_REQ=2, CNT_W=16 and DROP_W=8.
REQ-022 The 2-way round-robin priority logic, including the Last_Grant register, SHALL be a sub-module named rr_arb2.

Verification
REQ-023 Single write: Req0 valid with Addr=3, Data=0xDEADBEEF for one cycle -> next cycle Write_Reg=1, W_Addr=3, W_Data=0xDEADBEEF, Grant_Id=0; the cycle after, Write_Reg=0.
REQ-024 Contention: both requesters valid every cycle, Req0 Addr=1, Req1 Addr=2 -> Grant_Id alternates 0,1,0,1 starting with 0; Write_Reg stays 1; each Ready pulses every other cycle.
REQ-025 Drop: Req1 Addr=0, Data=0x5 -> Req1_Ready=1, no Write_Reg; Drop_Count=1 with RWA_STATS_EN, 0 without.
REQ-026 Back-to-back: Req0 valid for 4 cycles with Addr=4..7 and Req1 idle -> Write_Reg high for 4 consecutive cycles, W_Addr=4,5,6,7; with RWA_STATS_EN, Write_Count=4.
REQ-027 Reset mid-operation: both slots full and Reset asserted for one cycle -> Write_Reg=0 during reset and after, with no stale write issued; next contention grants Req0 first.
REQ-028 Saturation (RWA_STATS_EN): 300 address-0 transfers -> Drop_Count holds at 255.
